// File: rtl/mem_latency_responder_if.sv
// Handshake bundle for one port of mem_latency_responder: request levels, word address and ready pulse.
// The data bus itself is bidirectional and stays a plain inout port on the responder.
interface mem_latency_responder_if #(
   parameter int WORD_SIZE = 16
) ();
   logic                 readM;
   logic                 writeM;
   logic [WORD_SIZE-1:0] address;
   logic                 ready;

   modport master (
      output readM,
      output writeM,
      output address,
      input  ready
   );

   modport slave (
      input  readM,
      input  writeM,
      input  address,
      output ready
   );
endinterface

// File: rtl/mem_latency_responder.sv
// Unified-array memory responder for split instruction/data ports with programmable latency and ready pulse.
// Optional MEM_STATS_EN adds rd_count/wr_count commit counters.
module mem_latency_responder #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   mem_latency_responder_if.slave i_bus,
   inout  wire  [WORD_SIZE-1:0]   i_data,
   mem_latency_responder_if.slave d_bus,
   inout  wire  [WORD_SIZE-1:0]   d_data
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]            rd_count,
   output logic [15:0]            wr_count
`endif
);

   localparam int         MEM_DEPTH = 2 ** ADDR_BITS;
   localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]           state;
   logic [3:0]           cnt;
   logic                 last_grant_d;
   logic                 op_write;
   logic [ADDR_BITS-1:0] addr_q;
   logic [WORD_SIZE-1:0] wdata_q;
   logic [WORD_SIZE-1:0] rdata_q;
   logic [WORD_SIZE-1:0] mem [0:MEM_DEPTH-1];

   logic                 i_req;
   logic                 d_req;
   logic                 start;
   logic                 start_d;
   logic                 commit;
   logic                 sel_write;
   logic [ADDR_BITS-1:0] sel_addr;
   logic [WORD_SIZE-1:0] sel_wdata;
   logic                 unused_addr_bits;

   assign i_req = i_bus.readM | i_bus.writeM;
   assign d_req = d_bus.readM | d_bus.writeM;
   assign unused_addr_bits = &{1'b0, i_bus.address[WORD_SIZE-1:ADDR_BITS],
                               d_bus.address[WORD_SIZE-1:ADDR_BITS]};

   // last_grant_d doubles as the current grant while busy; on leaving RESP only the other port may start,
   // so the port whose ready is high is never re-sampled in that cycle.
   always_comb begin
      start   = 1'b0;
      start_d = 1'b0;
      case (state)
         ST_IDLE: begin
            start   = i_req | d_req;
            start_d = d_req & (~i_req | ~last_grant_d);
         end
         ST_RESP: begin
            start   = last_grant_d ? i_req : d_req;
            start_d = ~last_grant_d;
         end
         default: ;
      endcase
   end

   assign sel_write = start_d ? d_bus.writeM : i_bus.writeM;
   assign sel_addr  = start_d ? d_bus.address[ADDR_BITS-1:0] : i_bus.address[ADDR_BITS-1:0];
   assign sel_wdata = start_d ? d_data : i_data;
   assign commit    = (state == ST_WAIT) && (cnt == 4'd0);

   // The counter is always passed through WAIT so that ready lands in the cycle after edge T0+LATENCY,
   // LATENCY=1 included.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         cnt          <= 4'd0;
         last_grant_d <= 1'b0;
         op_write     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_RESP: begin
               if (start) begin
                  state        <= ST_WAIT;
                  cnt          <= CNT_LOAD;
                  last_grant_d <= start_d;
                  op_write     <= sel_write;
                  addr_q       <= sel_addr;
                  wdata_q      <= sel_wdata;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         if (op_write) begin
            mem[addr_q] <= wdata_q;
         end else begin
            rdata_q <= mem[addr_q];
         end
      end
   end

   assign i_bus.ready = (state == ST_RESP) & ~last_grant_d;
   assign d_bus.ready = (state == ST_RESP) & last_grant_d;
   assign i_data = (i_bus.ready & ~op_write) ? rdata_q : {WORD_SIZE{1'bz}};
   assign d_data = (d_bus.ready & ~op_write) ? rdata_q : {WORD_SIZE{1'bz}};

`ifdef MEM_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else if (commit) begin
         if (op_write) begin
            wr_count <= wr_count + 16'd1;
         end else begin
            rd_count <= rd_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_latency_responder.sv
// Directed self-checking bench for mem_latency_responder: a LATENCY=4 instance for timing, arbitration,
// wrap, reset and read+write cases, and a LATENCY=1 instance for back-to-back accesses and stats.
module tb_mem_latency_responder;

   logic clk;
   logic reset_n;
   int   compared;
   int   mismatched;

   mem_latency_responder_if #(.WORD_SIZE(16)) i0_if ();
   mem_latency_responder_if #(.WORD_SIZE(16)) d0_if ();
   mem_latency_responder_if #(.WORD_SIZE(16)) i1_if ();
   mem_latency_responder_if #(.WORD_SIZE(16)) d1_if ();

   wire [15:0] i0_data;
   wire [15:0] d0_data;
   wire [15:0] i1_data;
   wire [15:0] d1_data;

   logic       i0_drv, d0_drv, d1_drv;
   logic [15:0] i0_wval, d0_wval, d1_wval;

   // Undriven buses float high, so a released bus reads 16'hFFFF.
   pullup (i0_data);
   pullup (d0_data);
   pullup (i1_data);
   pullup (d1_data);

   assign i0_data = i0_drv ? i0_wval : 16'hzzzz;
   assign d0_data = d0_drv ? d0_wval : 16'hzzzz;
   assign d1_data = d1_drv ? d1_wval : 16'hzzzz;

`ifdef MEM_STATS_EN
   logic [15:0] rd_count0, wr_count0, rd_count1, wr_count1;
`endif

   mem_latency_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(4)) dut0 (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_bus    (i0_if),
      .i_data   (i0_data),
      .d_bus    (d0_if),
      .d_data   (d0_data)
`ifdef MEM_STATS_EN
      ,
      .rd_count (rd_count0),
      .wr_count (wr_count0)
`endif
   );

   mem_latency_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) dut1 (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_bus    (i1_if),
      .i_data   (i1_data),
      .d_bus    (d1_if),
      .d_data   (d1_data)
`ifdef MEM_STATS_EN
      ,
      .rd_count (rd_count1),
      .wr_count (wr_count1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   // which: 0 = dut0 I port, 1 = dut0 D port, 2 = dut1 D port
   task automatic applyStimulus(input int which, input logic rd, input logic wr,
                                input logic [15:0] addr, input logic [15:0] wdata);
      case (which)
         0: begin
            i0_if.readM = rd; i0_if.writeM = wr; i0_if.address = addr;
            i0_wval = wdata; i0_drv = wr;
         end
         1: begin
            d0_if.readM = rd; d0_if.writeM = wr; d0_if.address = addr;
            d0_wval = wdata; d0_drv = wr;
         end
         default: begin
            d1_if.readM = rd; d1_if.writeM = wr; d1_if.address = addr;
            d1_wval = wdata; d1_drv = wr;
         end
      endcase
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic readyOf(input int which);
      case (which)
         0:       return i0_if.ready;
         1:       return d0_if.ready;
         default: return d1_if.ready;
      endcase
   endfunction

   function automatic logic [15:0] dataOf(input int which);
      case (which)
         0:       return i0_data;
         1:       return d0_data;
         default: return d1_data;
      endcase
   endfunction

   task automatic pulseReset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Request issued at a negedge; k counts negedges after sample edge T0, so ready is expected at k=lat+1.
   task automatic doAccess(input int which, input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] expected, input string tag);
      int lat;
      lat = (which == 2) ? 1 : 4;
      applyStimulus(which, rd, wr, addr, wdata);
      for (int k = 1; k <= lat + 2; k++) begin
         @(negedge clk);
         if (k <= lat) begin
            checkOutput({tag, "_wait_ready"}, {15'd0, readyOf(which)}, 16'd0);
            if (!wr && k == lat) checkOutput({tag, "_pre_data"}, dataOf(which), 16'hFFFF);
         end else if (k == lat + 1) begin
            checkOutput({tag, "_ready"}, {15'd0, readyOf(which)}, 16'd1);
            applyStimulus(which, 1'b0, 1'b0, 16'h0000, 16'h0000);
            #1;
            checkOutput({tag, "_resp_data"}, dataOf(which), wr ? 16'hFFFF : expected);
         end else begin
            checkOutput({tag, "_post_ready"}, {15'd0, readyOf(which)}, 16'd0);
            checkOutput({tag, "_post_data"}, dataOf(which), 16'hFFFF);
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset_n    = 1'b0;
      i0_drv = 1'b0; d0_drv = 1'b0; d1_drv = 1'b0;
      i0_wval = 16'h0; d0_wval = 16'h0; d1_wval = 16'h0;
      applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
      applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);
      applyStimulus(2, 1'b0, 1'b0, 16'h0, 16'h0);
      i1_if.readM = 1'b0; i1_if.writeM = 1'b0; i1_if.address = 16'h0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] reset state");
      checkOutput("rst_i_ready", {15'd0, i0_if.ready}, 16'd0);
      checkOutput("rst_d_ready", {15'd0, d0_if.ready}, 16'd0);
      checkOutput("rst_i_data", i0_data, 16'hFFFF);
      checkOutput("rst_d_data", d0_data, 16'hFFFF);

      $display("[TB] write then read, latency 4");
      doAccess(1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, "t1_wr");
      doAccess(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "t1_rd");
      doAccess(1, 1'b0, 1'b1, 16'h0020, 16'h2222, 16'h0000, "t2_prep");

      $display("[TB] simultaneous requests after reset");
      pulseReset();
      applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      applyStimulus(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checkOutput("t2_d_wait", {15'd0, d0_if.ready}, 16'd0);
         checkOutput("t2_i_wait", {15'd0, i0_if.ready}, 16'd0);
      end
      @(negedge clk);
      checkOutput("t2_d_ready", {15'd0, d0_if.ready}, 16'd1);
      checkOutput("t2_d_data", d0_data, 16'h2222);
      checkOutput("t2_i_not_ready", {15'd0, i0_if.ready}, 16'd0);
      applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      for (int k = 6; k <= 9; k++) begin
         @(negedge clk);
         checkOutput("t2_i_wait2", {15'd0, i0_if.ready}, 16'd0);
         checkOutput("t2_d_idle", {15'd0, d0_if.ready}, 16'd0);
      end
      @(negedge clk);
      checkOutput("t2_i_ready", {15'd0, i0_if.ready}, 16'd1);
      checkOutput("t2_i_data", i0_data, 16'hBEEF);
      applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      checkOutput("t2_i_post", {15'd0, i0_if.ready}, 16'd0);
      checkOutput("t2_i_post_data", i0_data, 16'hFFFF);

      $display("[TB] address wrap across ports");
      doAccess(1, 1'b0, 1'b1, 16'h0105, 16'h1234, 16'h0000, "t3_wr");
      doAccess(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, "t3_rd");

      $display("[TB] reset during pending write");
      doAccess(1, 1'b0, 1'b1, 16'h0030, 16'h1111, 16'h0000, "t4_prep");
      applyStimulus(1, 1'b0, 1'b1, 16'h0030, 16'hAAAA);
      @(negedge clk);
      checkOutput("t4_k1", {15'd0, d0_if.ready}, 16'd0);
      @(negedge clk);
      reset_n = 1'b0;
      applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      #1;
      checkOutput("t4_in_reset", {15'd0, d0_if.ready}, 16'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput("t4_no_ready", {15'd0, d0_if.ready}, 16'd0);
      end
      doAccess(1, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1111, "t4_rd");

      $display("[TB] read and write both high");
      doAccess(1, 1'b1, 1'b1, 16'h0040, 16'h5555, 16'h0000, "t5_rw");
      doAccess(1, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5555, "t5_rd");

      $display("[TB] latency 1 back-to-back");
      pulseReset();
      doAccess(2, 1'b0, 1'b1, 16'h0001, 16'h0A01, 16'h0000, "t6_wr1");
      doAccess(2, 1'b0, 1'b1, 16'h0002, 16'h0A02, 16'h0000, "t6_wr2");
      doAccess(2, 1'b0, 1'b1, 16'h0003, 16'h0A03, 16'h0000, "t6_wr3");
      doAccess(2, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0A01, "t6_rd1");
      doAccess(2, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0A03, "t6_rd3");
`ifdef MEM_STATS_EN
      checkOutput("t6_wr_count", wr_count1, 16'd3);
      checkOutput("t6_rd_count", rd_count1, 16'd2);
      checkOutput("t6_dut0_wr_count", wr_count0, 16'd0);
      checkOutput("t6_dut0_rd_count", rd_count0, 16'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
